// File: rtl/apmu_ibex_pkg.sv
// Shared APMU/Ibex definitions for the performance-counter bank: dump FSM states,
// CSR field selects and bank sizing limits.
package apmu_ibex_pkg;

    localparam int PMC_MAX_COUNTERS = 29;
    localparam int PMC_EVSEL_W      = 5;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

    typedef enum logic [1:0] {
        PMC_SEL_LO  = 2'd0,
        PMC_SEL_HI  = 2'd1,
        PMC_SEL_EVT = 2'd2,
        PMC_SEL_INH = 2'd3
    } pmc_csr_sel_e;

    // Index width that stays legal for a single-counter bank.
    function automatic int pmc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apmu_pmc_counter.sv
// One performance counter with its event-select register and, when
// APMU_PMC_OVF_IRQ_EN is defined, an overflow-sticky bit.
module apmu_pmc_counter
    import apmu_ibex_pkg::*;
#(
    parameter int CounterWidth = 48,
    parameter int NumEvents    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumEvents-1:0]    events,
    input  logic                    inhibit,
    input  logic                    we_lo,
    input  logic                    we_hi,
    input  logic                    we_evt,
    input  logic [31:0]             wdata,
    output logic [CounterWidth-1:0] count,
    output logic [CounterWidth-1:0] count_next,
    output logic [PMC_EVSEL_W-1:0]  evsel
`ifdef APMU_PMC_OVF_IRQ_EN
    ,
    output logic                    sticky
`endif
);

    logic [CounterWidth-1:0] count_reg;
    logic [PMC_EVSEL_W-1:0]  evsel_reg;
    logic [31:0]             event_pad;
    logic                    hit;

    // Zero-padding to 32 makes any select beyond NumEvents read a constant 0.
    assign event_pad = 32'(events);
    assign hit       = !inhibit && event_pad[evsel_reg];

    always_comb begin
        count_next = count_reg + CounterWidth'(hit);
        if (we_lo) begin
            count_next[31:0] = wdata;
        end
        if (we_hi) begin
            count_next[CounterWidth-1:32] = wdata[CounterWidth-33:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            evsel_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (we_evt) begin
                evsel_reg <= wdata[PMC_EVSEL_W-1:0];
            end
        end
    end

    assign count = count_reg;
    assign evsel = evsel_reg;

`ifdef APMU_PMC_OVF_IRQ_EN
    logic sticky_reg;
    logic wrap;

    // A CSR write overrides the increment, so it can never be a wrap.
    assign wrap = hit && (&count_reg) && !we_lo && !we_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (we_lo || we_hi) begin
            sticky_reg <= 1'b0;
        end else if (wrap) begin
            sticky_reg <= 1'b1;
        end
    end

    assign sticky = sticky_reg;
`endif

endmodule

// File: rtl/apmu_pmc_bank.sv
// Bank of performance counters with CSR access, snapshot and streamed dump to the APMU.
// Optional overflow interrupt and sticky bits are enabled by defining APMU_PMC_OVF_IRQ_EN.
module apmu_pmc_bank
    import apmu_ibex_pkg::*;
#(
    parameter  int NumCounters  = 8,
    parameter  int CounterWidth = 48,
    parameter  int NumEvents    = 16,
    localparam int IdxW         = pmc_idx_w(NumCounters)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumEvents-1:0]    event_i,
    input  logic                    csr_we_i,
    input  logic [1:0]              csr_sel_i,
    input  logic [IdxW-1:0]         csr_idx_i,
    input  logic [31:0]             csr_wdata_i,
    output logic [31:0]             csr_rdata_o,
    input  logic                    dump_i,
    output logic                    pmc_req_o,
    input  logic                    pmc_gnt_i,
    output logic                    pmc_valid_o,
    input  logic                    pmc_ready_i,
    output logic [IdxW-1:0]         pmc_idx_o,
    output logic [CounterWidth-1:0] pmc_data_o,
    input  logic                    pmc_done_i,
    output logic [1:0]              pmc_state_o,
    output logic                    ovf_irq_o
);

    if (NumCounters < 1 || NumCounters > PMC_MAX_COUNTERS) begin : g_bad_num_counters
        $error("apmu_pmc_bank: NumCounters out of range");
    end
    if (CounterWidth < 33 || CounterWidth > 64) begin : g_bad_counter_width
        $error("apmu_pmc_bank: CounterWidth out of range");
    end
    if (NumEvents < 1 || NumEvents > 32) begin : g_bad_num_events
        $error("apmu_pmc_bank: NumEvents out of range");
    end

    pmc_csr_sel_e            sel;
    logic                    idx_ok;
    logic [NumCounters-1:0]  inhibit_reg;
    logic [CounterWidth-1:0] count_val   [NumCounters];
    logic [CounterWidth-1:0] count_nxt   [NumCounters];
    logic [CounterWidth-1:0] shadow_reg  [NumCounters];
    logic [PMC_EVSEL_W-1:0]  evsel_val   [NumCounters];
    logic [31:0]             inh_rdata;

    pmc_op_e                 state_reg;
    logic                    req_reg;
    logic                    valid_reg;
    logic [IdxW-1:0]         idx_reg;
    logic [IdxW-1:0]         idx_inc;
    logic                    last_word;
    logic [CounterWidth-1:0] data_reg;

    assign sel    = pmc_csr_sel_e'(csr_sel_i);
    assign idx_ok = (32'(csr_idx_i) < NumCounters);

`ifdef APMU_PMC_OVF_IRQ_EN
    logic [NumCounters-1:0] sticky_val;
    logic                   ovf_irq_reg;
`endif

    // Counters: CSR writes target exactly one in-range index.
    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_counter
        logic hit_idx;
        assign hit_idx = csr_we_i && idx_ok && (csr_idx_i == IdxW'(gi));

        apmu_pmc_counter #(
            .CounterWidth (CounterWidth),
            .NumEvents    (NumEvents)
        ) u_counter (
            .clk        (clk_i),
            .rst        (rst_i),
            .events     (event_i),
            .inhibit    (inhibit_reg[gi]),
            .we_lo      (hit_idx && (sel == PMC_SEL_LO)),
            .we_hi      (hit_idx && (sel == PMC_SEL_HI)),
            .we_evt     (hit_idx && (sel == PMC_SEL_EVT)),
            .wdata      (csr_wdata_i),
            .count      (count_val[gi]),
            .count_next (count_nxt[gi]),
            .evsel      (evsel_val[gi])
`ifdef APMU_PMC_OVF_IRQ_EN
            ,
            .sticky     (sticky_val[gi])
`endif
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inhibit_reg <= '1;
        end else if (csr_we_i && (sel == PMC_SEL_INH)) begin
            inhibit_reg <= csr_wdata_i[NumCounters-1:0];
        end
    end

`ifdef APMU_PMC_OVF_IRQ_EN
    // Sticky bits sit directly above the inhibit mask; bits past 31 are dropped.
    assign inh_rdata = 32'({sticky_val, inhibit_reg});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_irq_reg <= 1'b0;
        end else begin
            ovf_irq_reg <= |(sticky_val & ~inhibit_reg);
        end
    end

    assign ovf_irq_o = ovf_irq_reg;
`else
    assign inh_rdata = 32'(inhibit_reg);
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        csr_rdata_o = '0;
        case (sel)
            PMC_SEL_LO:  if (idx_ok) csr_rdata_o = count_val[csr_idx_i][31:0];
            PMC_SEL_HI:  if (idx_ok) csr_rdata_o = 32'(count_val[csr_idx_i][CounterWidth-1:32]);
            PMC_SEL_EVT: if (idx_ok) csr_rdata_o = 32'(evsel_val[csr_idx_i]);
            PMC_SEL_INH: csr_rdata_o = inh_rdata;
            default:     csr_rdata_o = '0;
        endcase
    end

    // Snapshot captures the values the counters take at the trigger edge,
    // including any increment or CSR write happening in that cycle.
    always_ff @(posedge clk_i) begin
        if ((state_reg == PMC_IDLE) && dump_i) begin
            for (int k = 0; k < NumCounters; k++) begin
                shadow_reg[k] <= count_nxt[k];
            end
        end
    end

    assign idx_inc   = idx_reg + IdxW'(1);
    assign last_word = (idx_reg == IdxW'(NumCounters - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= PMC_IDLE;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                PMC_IDLE: begin
                    if (dump_i) begin
                        state_reg <= PMC_REQ;
                        req_reg   <= 1'b1;
                    end
                end
                PMC_REQ: begin
                    if (pmc_gnt_i) begin
                        state_reg <= PMC_WFP;
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                        idx_reg   <= '0;
                        data_reg  <= shadow_reg[0];
                    end
                end
                PMC_WFP: begin
                    if (pmc_ready_i) begin
                        if (last_word) begin
                            state_reg <= PMC_WFO;
                            valid_reg <= 1'b0;
                            idx_reg   <= '0;
                            data_reg  <= '0;
                        end else begin
                            idx_reg   <= idx_inc;
                            data_reg  <= shadow_reg[idx_inc];
                        end
                    end
                end
                PMC_WFO: begin
                    if (pmc_done_i) begin
                        state_reg <= PMC_IDLE;
                    end
                end
                default: begin
                    state_reg <= PMC_IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pmc_req_o   = req_reg;
    assign pmc_valid_o = valid_reg;
    assign pmc_idx_o   = idx_reg;
    assign pmc_data_o  = data_reg;
    assign pmc_state_o = state_reg;

endmodule

// File: tb/tb_apmu_pmc_bank.sv
// Self-checking bench for apmu_pmc_bank: CSR counting, wrap/overflow, snapshot dump with
// backpressure, asynchronous reset mid-dump and CSR/event collision.
module tb_apmu_pmc_bank;

    localparam int NC = 8;
    localparam int CW = 48;
    localparam int NE = 16;
    localparam int IW = 3;

    localparam logic [1:0] S_LO  = 2'd0;
    localparam logic [1:0] S_HI  = 2'd1;
    localparam logic [1:0] S_EVT = 2'd2;
    localparam logic [1:0] S_INH = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] event_i;
    logic          csr_we;
    logic [1:0]    csr_sel;
    logic [IW-1:0] csr_idx;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          dump;
    logic          req;
    logic          gnt;
    logic          valid;
    logic          ready;
    logic [IW-1:0] pidx;
    logic [CW-1:0] pdata;
    logic          done;
    logic [1:0]    state;
    logic          irq;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] rd;

    apmu_pmc_bank #(.NumCounters(NC), .CounterWidth(CW), .NumEvents(NE)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .event_i     (event_i),
        .csr_we_i    (csr_we),
        .csr_sel_i   (csr_sel),
        .csr_idx_i   (csr_idx),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .dump_i      (dump),
        .pmc_req_o   (req),
        .pmc_gnt_i   (gnt),
        .pmc_valid_o (valid),
        .pmc_ready_i (ready),
        .pmc_idx_o   (pidx),
        .pmc_data_o  (pdata),
        .pmc_done_i  (done),
        .pmc_state_o (state),
        .ovf_irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] s, input int i, input logic [31:0] d);
        csr_we = 1'b1; csr_sel = s; csr_idx = IW'(i); csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] s, input int i, output logic [31:0] d);
        csr_sel = s; csr_idx = IW'(i);
        #1;
        d = csr_rdata;
    endtask

    // Consumes dump words with ready high, comparing against the queued snapshot.
    task automatic drain_dump(input string tag);
        int k;
        int cyc;
        k = 0; cyc = 0;
        ready = 1'b1;
        while (k < NC && cyc < 50) begin
            if (valid) begin
                e = exp_q.pop_front();
                n_cmp++; if (pidx !== IW'(k)) begin n_fail++; $display("FAIL %s_idx: got %0d expected %0d", tag, pidx, k); end
                n_cmp++; if (pdata !== e[CW-1:0]) begin n_fail++; $display("FAIL %s_data[%0d]: got %0h expected %0h", tag, k, pdata, e[CW-1:0]); end
                $display("beat %s idx=%0d data=%0h", tag, pidx, pdata);
                k++;
            end
            tick();
            cyc++;
        end
        ready = 1'b0;
        n_cmp++; if (k !== NC) begin n_fail++; $display("FAIL %s_words: got %0d expected %0d", tag, k, NC); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({req, valid, irq} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {req, valid, irq}); end
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
        n_cmp++; if ({pidx, pdata} !== '0) begin n_fail++; $display("FAIL rst_dump_out: got %0h expected 0", {pidx, pdata}); end
        rst = 1'b0;
        tick();
        exp_q.push_back(64'hFF);
        csr_read(S_INH, 0, rd); e = exp_q.pop_front();
        n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL rst_inhibit: got %0h expected %0h", rd, e[31:0]); end
        $display("reset inhibit=%0h state=%0d", rd, state);
    endtask

    task automatic test_count();
        csr_write(S_INH, 0, 32'h0);
        csr_write(S_EVT, 0, 32'd2);
        repeat (5) begin
            event_i[2] = 1'b1; tick();
            event_i[2] = 1'b0; tick();
        end
        exp_q.push_back(64'd5);
        for (int k = 1; k < NC; k++) exp_q.push_back(64'd0);
        for (int k = 0; k < NC; k++) begin
            csr_read(S_LO, k, rd); e = exp_q.pop_front();
            n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL count_lo[%0d]: got %0h expected %0h", k, rd, e[31:0]); end
            $display("count ctr%0d lo=%0h", k, rd);
        end
        csr_read(S_EVT, 0, rd);
        n_cmp++; if (rd !== 32'd2) begin n_fail++; $display("FAIL count_evsel0: got %0h expected 2", rd); end
    endtask

    task automatic test_wrap();
        logic exp_irq;
        logic [31:0] exp_inh;
`ifdef APMU_PMC_OVF_IRQ_EN
        exp_irq = 1'b1; exp_inh = 32'h200;
`else
        exp_irq = 1'b0; exp_inh = 32'h0;
`endif
        csr_write(S_HI, 1, 32'hFFFF);
        csr_write(S_LO, 1, 32'hFFFF_FFFE);
        csr_write(S_EVT, 1, 32'd5);
        event_i[5] = 1'b1;
        tick(); tick();
        event_i[5] = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wrap_irq_early: got %b expected 0", irq); end
        tick();
        n_cmp++; if (irq !== exp_irq) begin n_fail++; $display("FAIL wrap_irq: got %b expected %b", irq, exp_irq); end
        csr_read(S_LO, 1, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_lo: got %0h expected 0", rd); end
        csr_read(S_HI, 1, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_hi: got %0h expected 0", rd); end
        csr_read(S_INH, 0, rd);
        n_cmp++; if (rd !== exp_inh) begin n_fail++; $display("FAIL wrap_inh_sticky: got %0h expected %0h", rd, exp_inh); end
        csr_write(S_LO, 1, 32'h0);
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wrap_irq_clear: got %b expected 0", irq); end
        $display("wrap ctr1 cleared irq=%b", irq);
    endtask

    task automatic test_dump();
        int req_hi;
        int cyc;
        csr_write(S_INH, 0, 32'hFF);
        for (int k = 0; k < NC; k++) csr_write(S_LO, k, 32'(4 * k + 3));
        csr_write(S_INH, 0, 32'h0);
        exp_q.delete();
        exp_q.push_back(64'd4);
        for (int k = 1; k < NC; k++) exp_q.push_back(64'(4 * k + 3));
        dump = 1'b1; event_i[2] = 1'b1;
        tick();
        dump = 1'b0;
        req_hi = 0; cyc = 0;
        while (state !== 2'd2 && cyc < 20) begin
            if (req) req_hi++;
            if (req_hi == 4) gnt = 1'b1;
            tick();
            cyc++;
            if (cyc == 3) event_i[2] = 1'b0;
        end
        gnt = 1'b0;
        event_i[2] = 1'b0;
        n_cmp++; if (req_hi !== 4) begin n_fail++; $display("FAIL dump_req_cycles: got %0d expected 4", req_hi); end
        drain_dump("dump");
        n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL dump_wfo: got %0d expected 3", state); end
        csr_read(S_LO, 0, rd);
        n_cmp++; if (rd !== 32'd7) begin n_fail++; $display("FAIL dump_live_ctr0: got %0h expected 7", rd); end
        done = 1'b1; tick(); done = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL dump_idle: got %0d expected 0", state); end
    endtask

    task automatic test_back_to_back_stall();
        exp_q.delete();
        exp_q.push_back(64'd7);
        for (int k = 1; k < NC; k++) exp_q.push_back(64'(4 * k + 3));
        dump = 1'b1; tick(); dump = 1'b0;
        gnt = 1'b1; tick(); gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = exp_q[0];
            n_cmp++; if ({valid, pidx} !== {1'b1, IW'(0)}) begin n_fail++; $display("FAIL stall_idx: got v=%b idx=%0d expected v=1 idx=0", valid, pidx); end
            n_cmp++; if (pdata !== e[CW-1:0]) begin n_fail++; $display("FAIL stall_data: got %0h expected %0h", pdata, e[CW-1:0]); end
            if (i == 1) dump = 1'b1;
            tick();
            dump = 1'b0;
        end
        n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL stall_state: got %0d expected 2", state); end
        drain_dump("stall");
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL stall_wfo: got %0d expected 3", state); end
            tick();
        end
        done = 1'b1; tick(); done = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL stall_idle: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid_dump();
        dump = 1'b1; tick(); dump = 1'b0;
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL mid_req_pre: got %b expected 1", req); end
        rst = 1'b1; #1;
        n_cmp++; if ({req, state} !== 3'b000) begin n_fail++; $display("FAIL mid_req_rst: got req=%b state=%0d expected 0/0", req, state); end
        tick(); rst = 1'b0; tick();
        dump = 1'b1; tick(); dump = 1'b0;
        gnt = 1'b1; tick(); gnt = 1'b0;
        n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre: got %b expected 1", valid); end
        rst = 1'b1; #1;
        n_cmp++; if ({valid, req, state} !== 4'b0000) begin n_fail++; $display("FAIL mid_valid_rst: got v=%b r=%b s=%0d expected 0", valid, req, state); end
        n_cmp++; if (pdata !== '0) begin n_fail++; $display("FAIL mid_data_rst: got %0h expected 0", pdata); end
        tick(); rst = 1'b0; tick();
        csr_read(S_INH, 0, rd);
        n_cmp++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL mid_inhibit: got %0h expected ff", rd); end
        $display("reset mid-dump state=%0d inhibit=%0h", state, rd);
    endtask

    task automatic test_csr_collide();
        csr_write(S_INH, 0, 32'h0);
        csr_write(S_EVT, 2, 32'd3);
        event_i[3] = 1'b1;
        csr_write(S_LO, 2, 32'h10);
        event_i[3] = 1'b0;
        csr_read(S_LO, 2, rd);
        n_cmp++; if (rd !== 32'h10) begin n_fail++; $display("FAIL collide_lo: got %0h expected 10", rd); end
        csr_write(S_EVT, 3, 32'd20);
        event_i = '1;
        repeat (3) tick();
        event_i = '0;
        exp_q.delete();
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h13);
        exp_q.push_back(64'd3);
        exp_q.push_back(64'd20);
        csr_read(S_LO, 3, rd); e = exp_q.pop_front();
        n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL evsel_oob_ctr3: got %0h expected %0h", rd, e[31:0]); end
        csr_read(S_LO, 2, rd); e = exp_q.pop_front();
        n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL evsel_ctr2: got %0h expected %0h", rd, e[31:0]); end
        csr_read(S_LO, 0, rd); e = exp_q.pop_front();
        n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL evsel_ctr0: got %0h expected %0h", rd, e[31:0]); end
        csr_read(S_EVT, 3, rd); e = exp_q.pop_front();
        n_cmp++; if (rd !== e[31:0]) begin n_fail++; $display("FAIL evsel_read3: got %0h expected %0h", rd, e[31:0]); end
        $display("collide ctr2=%0h evsel3=%0h", 32'h13, rd);
    endtask

    initial begin
        rst = 1'b1; event_i = '0; csr_we = 1'b0; csr_sel = 2'd0; csr_idx = '0;
        csr_wdata = '0; dump = 1'b0; gnt = 1'b0; ready = 1'b0; done = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_dump();
        test_back_to_back_stall();
        test_reset_mid_dump();
        test_csr_collide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
